instr_encoder: RTL

- Instruction encoder for the single-cycle CPU: the inverse of the control unit's decode path.
- Accepts mnemonic requests with register/immediate fields over a valid/ready handshake and packs them into 32-bit MIPS words.
- Buffers the words in a small FIFO and presents them to the instruction-memory loader or the CPU bench stimulus port.
- Covers exactly the instruction subset the control unit decodes: ADD, SUB, AND, OR, NOR, SLT, LW, SW, BEQ.

---
 rtl/instr_enc_pkg.sv | 42 ++++
 rtl/instr_encoder_fifo.sv | 52 +++++
 rtl/instr_encoder.sv | 100 ++++++++++
 3 files changed

// File: rtl/instr_enc_pkg.sv
// Shared encodings for the MIPS instruction encoder: mnemonic codes, opcodes, funct codes.
// Optional feature macro used by instr_encoder: ENC_BRANCH_DELAY_EN.
package instr_enc_pkg;

    typedef enum logic [3:0] {
        MN_ADD = 4'd0,
        MN_SUB = 4'd1,
        MN_AND = 4'd2,
        MN_OR  = 4'd3,
        MN_NOR = 4'd4,
        MN_SLT = 4'd5,
        MN_LW  = 4'd6,
        MN_SW  = 4'd7,
        MN_BEQ = 4'd8
    } mnem_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_NOR = 6'd39;
    localparam logic [5:0] FN_SLT = 6'd42;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [31:0] rtype_word(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype_word(input logic [5:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous DEPTH x 32 FIFO with occupancy count; head word is forced to 0 while empty.
module instr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [31:0]                din,
    input  logic                       pop,
    output logic [31:0]                dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count < FULL);
    assign do_pop  = pop && (count != '0);
    assign dout    = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs mnemonic requests into 32-bit MIPS words and queues them for the loader.
// Define ENC_BRANCH_DELAY_EN to insert a NOP delay slot after every BEQ.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_mnem,
    input  logic [4:0]             in_rs,
    input  logic [4:0]             in_rt,
    input  logic [4:0]             in_rd,
    input  logic [15:0]            in_imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_illegal
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    mnem_t       mnem;
    logic        legal;
    logic [31:0] enc_word;
    logic        not_full;
    logic        accept;
    logic        push;
    logic [31:0] push_word;

    assign mnem     = mnem_t'(in_mnem);
    assign not_full = (count < FULL);
    assign accept   = in_valid && in_ready;

    always_comb begin
        legal    = 1'b1;
        enc_word = '0;
        case (mnem)
            MN_ADD:  enc_word = rtype_word(in_rs, in_rt, in_rd, FN_ADD);
            MN_SUB:  enc_word = rtype_word(in_rs, in_rt, in_rd, FN_SUB);
            MN_AND:  enc_word = rtype_word(in_rs, in_rt, in_rd, FN_AND);
            MN_OR:   enc_word = rtype_word(in_rs, in_rt, in_rd, FN_OR);
            MN_NOR:  enc_word = rtype_word(in_rs, in_rt, in_rd, FN_NOR);
            MN_SLT:  enc_word = rtype_word(in_rs, in_rt, in_rd, FN_SLT);
            MN_LW:   enc_word = itype_word(OP_LW, in_rs, in_rt, in_imm);
            MN_SW:   enc_word = itype_word(OP_SW, in_rs, in_rt, in_imm);
            MN_BEQ:  enc_word = itype_word(OP_BEQ, in_rs, in_rt, in_imm);
            default: legal = 1'b0;
        endcase
    end

`ifdef ENC_BRANCH_DELAY_EN
    logic nop_pending;
    logic nop_push;

    // in_ready stays low while the delay-slot NOP waits, so the two push sources never collide.
    assign in_ready  = not_full && !nop_pending;
    assign nop_push  = nop_pending && not_full;
    assign push      = nop_push || (accept && legal);
    assign push_word = nop_push ? NOP_WORD : enc_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nop_pending <= 1'b0;
        end else if (accept && (mnem == MN_BEQ)) begin
            nop_pending <= 1'b1;
        end else if (nop_push) begin
            nop_pending <= 1'b0;
        end
    end
`else
    assign in_ready  = not_full;
    assign push      = accept && legal;
    assign push_word = enc_word;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept && !legal;
        end
    end

    assign out_valid = (count != '0);

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_word),
        .pop   (out_valid && out_ready),
        .dout  (out_instr),
        .count (count)
    );

endmodule
